// File: rtl/idelay_window_decider_if.sv
// Scanner <-> window-decider bus: per-sample strobe/data going in, scan results coming back.
// The scanner drives the master side; the decider is the slave.
interface idelay_window_decider_if #(
  parameter int DW = 5,
  parameter int MW = 2,
  parameter int LW = 8
);
  localparam int RW = DW + MW + 1;

  logic          start;
  logic          strobe;
  logic [DW-1:0] tap;
  logic [MW-1:0] micro;
  logic          odd;
  logic [LW-1:0] lane_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] idelay_opt;
  logic [RW-1:0] win_len;
  logic          good_enough;

  modport master (
    output start, strobe, tap, micro, odd, lane_data,
    input  busy, done, idelay_opt, win_len, good_enough
  );

  modport slave (
    input  start, strobe, tap, micro, odd, lane_data,
    output busy, done, idelay_opt, win_len, good_enough
  );
endinterface

// File: rtl/idelay_window_decider.sv
// Eye-window decider: classifies each scan sample, tracks the longest run of valid samples,
// and reports the run's centre tap, length and pass flag when the final index has been processed.
module idelay_window_decider #(
  parameter int                   DW      = 5,
  parameter int                   MW      = 2,
  parameter int                   LW      = 8,
  parameter int                   NPAT    = 4,
  parameter logic [NPAT*LW-1:0]   PAT0    = {8'h43, 8'h0d, 8'h34, 8'hd0},
  parameter logic [NPAT*LW-1:0]   PAT1    = {8'h39, 8'he4, 8'h93, 8'h4e},
  parameter int                   MIN_WIN = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  idelay_window_decider_if.slave   bus
);

  localparam int IW = DW + MW;
  localparam int RW = DW + MW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINISH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IW-1:0]   w_idx;
  logic            w_accept;
  logic            w_last_in_flight;
  logic [RW-1:0]   w_run_nxt;

  logic            r_vld_p1;
  logic            r_valid_p1;
  logic            r_last_p1;
  logic [IW-1:0]   r_idx_p1;

  logic [RW-1:0]   r_run_p2;
  logic [RW-1:0]   r_best_p2;
  logic [RW-1:0]   r_best_end_p2;

  logic            r_done;
  logic [DW-1:0]   r_idelay_opt;
  logic [RW-1:0]   r_win_len;
  logic            r_good_enough;

  function automatic logic f_match(input logic [LW-1:0] data, input logic sel);
    logic m;
    m = 1'b0;
    for (int k = 0; k < NPAT; k++) begin
      m = m | (sel ? (data == PAT1[k*LW +: LW]) : (data == PAT0[k*LW +: LW]));
    end
    return m;
  endfunction

  // Centre sample of a run ending at end_idx, reduced to a tap index; best must be non-zero.
  function automatic logic [DW-1:0] f_centre_tap(input logic [RW-1:0] best,
                                                 input logic [RW-1:0] end_idx);
    logic [RW-1:0] c;
    c = end_idx - ((best - RW'(1)) >> 1);
    return DW'(c >> MW);
  endfunction

  assign w_idx            = {bus.tap, bus.micro};
  // Once the last sample sits in stage 1, further strobes of this scan are refused.
  assign w_last_in_flight = r_vld_p1 & r_last_p1;
  assign w_accept         = (r_state == S_SCAN) & bus.strobe & ~bus.start & ~w_last_in_flight;
  assign w_run_nxt        = r_valid_p1 ? (r_run_p2 + RW'(1)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_IDLE;
      S_SCAN:   if (w_last_in_flight) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (bus.start) w_state_nxt = S_SCAN;
  end

  // Stage 1: classify the strobed sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_valid_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
      r_idx_p1   <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_valid_p1 <= f_match(bus.lane_data, bus.odd);
        r_last_p1  <= &w_idx;
        r_idx_p1   <= w_idx;
      end
    end
  end

  // Stage 2: run tracking; strict '>' keeps the earliest of equal-length windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_p2      <= '0;
      r_best_p2     <= '0;
      r_best_end_p2 <= '0;
    end else if (bus.start) begin
      r_run_p2      <= '0;
      r_best_p2     <= '0;
      r_best_end_p2 <= '0;
    end else if (r_vld_p1) begin
      r_run_p2 <= w_run_nxt;
      if (w_run_nxt > r_best_p2) begin
        r_best_p2     <= w_run_nxt;
        r_best_end_p2 <= {1'b0, r_idx_p1};
      end
    end
  end

  // Result stage: outputs change only alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done        <= 1'b0;
      r_idelay_opt  <= '0;
      r_win_len     <= '0;
      r_good_enough <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_FINISH) && !bus.start) begin
        r_done    <= 1'b1;
        r_win_len <= r_best_p2;
        if (r_best_p2 == '0) begin
          r_idelay_opt  <= '0;
          r_good_enough <= 1'b0;
        end else begin
          r_idelay_opt  <= f_centre_tap(r_best_p2, r_best_end_p2);
          r_good_enough <= (r_best_p2 >= RW'(MIN_WIN));
        end
      end
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.idelay_opt  = r_idelay_opt;
  assign bus.win_len     = r_win_len;
  assign bus.good_enough = r_good_enough;

endmodule

// File: tb/tb_idelay_window_decider.sv
// Scoreboard bench for idelay_window_decider: each scan pushes its expected result,
// and a done-driven monitor pops and compares it.
module tb_idelay_window_decider;

  localparam int DW = 5;
  localparam int MW = 2;
  localparam int LW = 8;
  localparam int RW = DW + MW + 1;

  typedef struct {
    logic [RW-1:0] len;
    logic [DW-1:0] opt;
    logic          good;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   last_strb_cyc;
  int   n_done;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  idelay_window_decider_if #(.DW(DW), .MW(MW), .LW(LW)) bus ();

  idelay_window_decider #(.DW(DW), .MW(MW), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("done_latency", cyc - last_strb_cyc, 3);
        chk("busy_at_done", bus.busy, 0);
        chk("win_len", bus.win_len, e.len);
        chk("idelay_opt", bus.idelay_opt, e.opt);
        chk("good_enough", bus.good_enough, e.good);
      end
    end
  end

  function automatic logic [7:0] pat(input int sc, input int i);
    logic [7:0] w0 [4];
    logic [7:0] w1 [4];
    logic       in_win;
    logic [7:0] bad;
    w0[0] = 8'h43; w0[1] = 8'h0d; w0[2] = 8'h34; w0[3] = 8'hd0;
    w1[0] = 8'h39; w1[1] = 8'he4; w1[2] = 8'h93; w1[3] = 8'h4e;
    bad = ((i % 2) == 1) ? 8'h39 : 8'h00;
    case (sc)
      0:       in_win = (i >= 40 && i <= 79);
      1:       in_win = (i >= 10 && i <= 29) || (i >= 90 && i <= 119);
      2:       in_win = (i <= 34) || (i >= 60 && i <= 94);
      default: in_win = 1'b1;
    endcase
    if (sc == 3)      return w1[i % 4];
    else if (sc == 0) return in_win ? 8'h43 : bad;
    else              return in_win ? w0[i % 4] : bad;
  endfunction

  task automatic send(input int i, input logic [7:0] d, input logic o);
    logic [6:0] idx;
    idx = 7'(i);
    @(posedge clk); #1;
    bus.strobe    = 1'b1;
    bus.tap       = idx[6:2];
    bus.micro     = idx[1:0];
    bus.lane_data = d;
    bus.odd       = o;
    last_strb_cyc = cyc;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.strobe = 1'b0;
    bus.start  = 1'b0;
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.strobe = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
  endtask

  task automatic run_scan(input int sc, input logic o, input exp_t e);
    start_pulse();
    for (int i = 0; i < 128; i++) send(i, pat(sc, i), o);
    idle_cycle();
    sb_q.push_back(e);
    wait_done();
  endtask

  initial begin
    int   d0;
    exp_t e;
    n_checks = 0;
    n_errors = 0;
    n_done   = 0;
    last_strb_cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.strobe = 1'b0; bus.tap = '0; bus.micro = '0;
    bus.odd = 1'b0; bus.lane_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_win_len", bus.win_len, 0);
    chk("rst_idelay_opt", bus.idelay_opt, 0);
    chk("rst_good", bus.good_enough, 0);
    rst_n = 1'b1;

    // Strobes in IDLE, including the last index, must be ignored.
    for (int i = 120; i < 128; i++) send(i, 8'h43, 1'b0);
    idle_cycle();
    repeat (6) @(negedge clk);
    chk("idle_strobe_no_done", n_done, 0);
    chk("idle_strobe_busy", bus.busy, 0);

    e = '{len: 8'd40,  opt: 5'd15, good: 1'b1}; run_scan(0, 1'b0, e);
    e = '{len: 8'd30,  opt: 5'd26, good: 1'b0}; run_scan(1, 1'b0, e);
    e = '{len: 8'd35,  opt: 5'd4,  good: 1'b1}; run_scan(2, 1'b0, e);
    e = '{len: 8'd0,   opt: 5'd0,  good: 1'b0}; run_scan(3, 1'b0, e);
    e = '{len: 8'd128, opt: 5'd16, good: 1'b1}; run_scan(3, 1'b1, e);

    // Asynchronous reset mid-scan: everything clears at once, no done for the aborted scan.
    start_pulse();
    for (int i = 0; i < 60; i++) send(i, pat(0, i), 1'b0);
    d0 = n_done;
    @(posedge clk); #1;
    bus.strobe = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_win_len", bus.win_len, 0);
    chk("abort_idelay_opt", bus.idelay_opt, 0);
    chk("abort_good", bus.good_enough, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", n_done, d0);

    e = '{len: 8'd40, opt: 5'd15, good: 1'b1}; run_scan(0, 1'b0, e);

    // Re-start mid-scan with a coincident valid strobe that must be dropped.
    start_pulse();
    for (int i = 0; i < 50; i++) send(i, pat(0, i), 1'b0);
    chk("hold_len_mid", bus.win_len, 40);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.strobe    = 1'b1;
    bus.tap       = '0;
    bus.micro     = '0;
    bus.lane_data = 8'h43;
    bus.odd       = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.strobe = 1'b0;
    chk("restart_busy", bus.busy, 1);
    for (int i = 0; i < 128; i++) begin
      send(i, pat(2, i), 1'b0);
      if (i == 100) begin
        chk("hold_len_restart", bus.win_len, 40);
        chk("hold_opt_restart", bus.idelay_opt, 15);
        chk("hold_good_restart", bus.good_enough, 1);
      end
    end
    idle_cycle();
    e = '{len: 8'd35, opt: 5'd4, good: 1'b1};
    sb_q.push_back(e);
    wait_done();
    chk("total_done_pulses", n_done, 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/idelay_window_decider.md
# idelay_window_decider

Parametrised eye-window decider for the IDELAY scanner. It consumes one strobed lane-data sample per (tap, micro-step) position of a scan. Each sample is classified against a programmable set of valid training words, and the block tracks the longest run of consecutive valid samples. When the last position is reached it reports the tap at the run's centre, the run length and a pass/fail flag. Results are held stable between scans, and a `done` pulse tells the scanner FSM when they are ready.

## Interface
- `DW`, 5: tap index width.
- `MW`, 2: micro-step index width. Samples per scan = 2^(DW+MW).
- `LW`, 8: lane data width.
- `NPAT`, 4: valid words per pattern set.
- `PAT0`, {8'h43,8'h0d,8'h34,8'hd0}: NPAT*LW packed valid words, used when `odd`=0.
- `PAT1`, {8'h39,8'he4,8'h93,8'h4e}: NPAT*LW packed valid words, used when `odd`=1.
- `MIN_WIN`, 31: minimum run length, in samples, for `good_enough`.
- RW (derived, not a parameter) = DW+MW+1.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a scan.
- `strobe`  in  1  qualifies `tap`, `micro`, `odd` and `lane_data` this cycle.
- `tap`  in  DW  IDELAY tap of this sample.
- `micro`  in  MW  micro-step of this sample.
- `odd`  in  1  pattern-set select for this sample.
- `lane_data`  in  LW  captured lane word.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse; results updated this cycle.
- `idelay_opt`  out  DW  centre tap of the best window.
- `win_len`  out  RW  best run length in samples.
- `good_enough`  out  1  `win_len` ≥ MIN_WIN.

## Operation
- Reset: `busy`, `done`, `idelay_opt`, `win_len`, `good_enough` and all internal state are 0.
- States:
  - IDLE → SCAN on `start`.
  - SCAN → FINISH on the strobe whose sample is the last index.
  - FINISH → IDLE after one cycle, pulsing `done`.
  - `start` in any state forces SCAN and clears run, best and best_end. Previous results stay on the outputs.
- Sample index idx = {tap, micro}. The last index is all-ones. Index order is not checked; run continuity follows strobe order.
- Strobes outside SCAN are ignored. If `start` and `strobe` occur in the same cycle, `start` wins and the strobe is dropped.
- Stage 1, on strobe: register valid = (`lane_data` equals any word of the selected set), along with idx and a last flag.
- Stage 2:
  - run_next = valid ? run+1 : 0.
  - If run_next > best (strictly greater), then best ← run_next and best_end ← idx. Ties keep the earliest window.
  - RW bits hold 2^(DW+MW) without overflow.
- FINISH:
  - centre = best_end − ((best−1)>>1), computed at RW width.
  - `idelay_opt` ← centre >> MW.
  - `win_len` ← best.
  - `good_enough` ← (best ≥ MIN_WIN).
  - If best = 0, then `idelay_opt` = 0, `win_len` = 0 and `good_enough` = 0.
- Outputs change only in the `done` cycle.

## Timing
- `busy` rises the cycle after `start` and falls together with the `done` pulse.
- Last strobe at cycle N:
  - valid registered at N+1;
  - best updated at N+2;
  - `done` and new outputs visible at N+3.
- Back-to-back strobes (one per cycle) are supported with no stall.
- `rst_n` asserted mid-scan clears everything immediately. No `done` is produced for the aborted scan.

## Test plan
- DW=5, MW=2, `odd`=0, 128 strobes; samples 40..79 carry 8'h43 and all others 8'h00 → `done` 3 cycles after the last strobe; `win_len`=40, `idelay_opt`=15, `good_enough`=1.
- Two windows, 10..29 (20 samples) and 90..119 (30 samples) → `win_len`=30, `idelay_opt`=26, `good_enough`=0.
- Tie: windows 0..34 and 60..94, each 35 samples → first kept; `idelay_opt`=4, `win_len`=35.
- All 128 samples valid, `odd`=1 with words cycling 8'h39/8'he4/8'h93/8'h4e → `win_len`=128, `idelay_opt`=16, `good_enough`=1. With `odd`=0 and the same data → `win_len`=0, `idelay_opt`=0, `good_enough`=0.
- Pulse `rst_n` low at sample 60 of a scan → all outputs 0 and no `done`. Then a full repeat of the first scenario → same results.
- Re-`start` at sample 50 → scan restarts, prior outputs held until the new `done`. Also: a strobe in IDLE, and a strobe coincident with `start`, are both ignored.
